// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC generator feeding an in-order prefetch FIFO with redirect support.
// Define ROM_REG_EN for a ROM with registered output (one in-flight fetch tracked by PC tag).
module instr_fetch #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [15:0] rom_address,
  input  logic [31:0] rom_data,
  output logic [31:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_addr
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [15:0]   pc_q, pc_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   data_mem [FIFO_DEPTH];
  logic [15:0]   pc_mem   [FIFO_DEPTH];

  logic          inflight;
  logic          issue;
  logic          pop;
  logic          push;
  logic [15:0]   push_pc;

  // Occupancy includes the in-flight word so a returning fetch always has a free slot.
  assign issue = !redirect && ((32'(count_q) + 32'(inflight)) < FIFO_DEPTH);
  assign pop   = instr_valid && instr_ready && !redirect;

`ifdef ROM_REG_EN
  logic        inflight_q;
  logic [15:0] inflight_pc_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      // issue is forced low on redirect, which also cancels the word in flight
      inflight_q <= issue;
      if (issue) inflight_pc_q <= pc_q;
    end
  end

  assign inflight = inflight_q;
  assign push     = inflight_q && !redirect;
  assign push_pc  = inflight_pc_q;
`else
  assign inflight = 1'b0;
  assign push     = issue;
  assign push_pc  = pc_q;
`endif

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect) begin
      pc_d    = redirect_addr;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (issue) pc_d = pc_q + 16'd1;
      if (push)  tail_d = tail_q + AW'(1);
      if (pop)   head_d = head_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      data_mem[tail_q] <= rom_data;
      pc_mem[tail_q]   <= push_pc;
    end
  end

  assign rom_address = pc_q;
  assign instr_valid = (count_q != '0);
  // Outputs read as zero when empty so reset presents instr=0 / instr_pc=0.
  assign instr       = instr_valid ? data_mem[head_q] : 32'h0;
  assign instr_pc    = instr_valid ? pc_mem[head_q]   : 16'h0;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: scoreboard of expected program-order PCs plus
// per-scenario directed checks. Honours ROM_REG_EN for the ROM model and latency.
module tb_instr_fetch;

  localparam logic [15:0] RESET_PC = 16'h0000;
`ifdef ROM_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] rom_address;
  logic [31:0] rom_data;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_addr = 16'h0;

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  logic [15:0] last_pc = 16'h0;
  logic [15:0] sb[$];

  instr_fetch #(
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(4)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .rom_address  (rom_address),
    .rom_data     (rom_data),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .redirect     (redirect),
    .redirect_addr(redirect_addr)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] rom_word(input logic [15:0] a);
    if (a == 16'h0000) return 32'h00010006;
    if (a == 16'h0001) return 32'h00002006;
    return {a ^ 16'h5A5A, a};
  endfunction

`ifdef ROM_REG_EN
  always @(posedge CLK) rom_data <= rom_word(rom_address);
`else
  assign rom_data = rom_word(rom_address);
`endif

  // Scoreboard: every transfer must match the next expected PC and its ROM word.
  always @(negedge CLK) begin
    if (!RST && instr_valid && instr_ready && !redirect) begin
      logic [15:0] exp_pc;
      xfer_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got pc %h instr %h, expected no transfer", instr_pc, instr);
      end else begin
        exp_pc = sb.pop_front();
        if (instr_pc !== exp_pc || instr !== rom_word(exp_pc)) begin
          errors++;
          $display("FAIL sb_xfer: got pc %h instr %h, expected pc %h instr %h",
                   instr_pc, instr, exp_pc, rom_word(exp_pc));
        end
      end
      last_pc = instr_pc;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic restart_sb(input logic [15:0] start);
    logic [15:0] p;
    sb.delete();
    p = start;
    for (int i = 0; i < 64; i++) begin
      sb.push_back(p);
      p = p + 16'd1;
    end
  endtask

  task automatic do_reset(input logic rdy);
    RST = 1'b1;
    redirect = 1'b0;
    instr_ready = rdy;
    tick();
    tick();
    RST = 1'b0;
    restart_sb(RESET_PC);
  endtask

  task automatic wait_xfers(input int n);
    int start;
    int budget;
    start = xfer_cnt;
    budget = 0;
    while ((xfer_cnt - start) < n && budget < 20) begin
      tick();
      budget++;
    end
    checks++;
    if ((xfer_cnt - start) < n) begin
      errors++;
      $display("FAIL wait_xfers: got %0d transfers, expected %0d", xfer_cnt - start, n);
    end
  endtask

  task automatic test_reset();
    tick();
    @(negedge CLK);
    checks += 4;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
    if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h expected 0", instr); end
    if (instr_pc !== 16'h0) begin errors++; $display("FAIL rst_pc: got %h expected 0", instr_pc); end
    if (rom_address !== RESET_PC) begin
      errors++; $display("FAIL rst_addr: got %h expected %h", rom_address, RESET_PC);
    end
    tick();
  endtask

  task automatic test_stream();
    int start;
    do_reset(1'b1);
    for (int c = 0; c < LAT; c++) begin
      @(negedge CLK);
      checks++;
      if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_early c%0d: got %b expected 0", c, instr_valid); end
      tick();
    end
    @(negedge CLK);
    checks += 3;
    if (instr_valid !== 1'b1) begin errors++; $display("FAIL stream_v0: got %b expected 1", instr_valid); end
    if (instr !== 32'h00010006) begin errors++; $display("FAIL stream_i0: got %h expected 00010006", instr); end
    if (instr_pc !== 16'h0000) begin errors++; $display("FAIL stream_p0: got %h expected 0000", instr_pc); end
    tick();
    @(negedge CLK);
    checks += 2;
    if (instr !== 32'h00002006) begin errors++; $display("FAIL stream_i1: got %h expected 00002006", instr); end
    if (instr_pc !== 16'h0001) begin errors++; $display("FAIL stream_p1: got %h expected 0001", instr_pc); end
    tick();
    start = xfer_cnt;
    repeat (10) tick();
    checks++;
    if (xfer_cnt - start != 10) begin
      errors++; $display("FAIL stream_rate: got %0d transfers expected 10", xfer_cnt - start);
    end
  endtask

  task automatic test_fill_drain();
    int start;
    do_reset(1'b0);
    repeat (8) tick();
    @(negedge CLK);
    checks += 3;
    if (rom_address !== RESET_PC + 16'd4) begin
      errors++; $display("FAIL fill_addr: got %h expected %h", rom_address, RESET_PC + 16'd4);
    end
    if (instr_valid !== 1'b1) begin errors++; $display("FAIL fill_valid: got %b expected 1", instr_valid); end
    if (instr_pc !== RESET_PC) begin errors++; $display("FAIL fill_head: got %h expected %h", instr_pc, RESET_PC); end
    tick();
    instr_ready = 1'b1;
    start = xfer_cnt;
    repeat (10) tick();
    checks += 2;
    if (xfer_cnt - start != 10) begin
      errors++; $display("FAIL drain_cnt: got %0d expected 10", xfer_cnt - start);
    end
    if (last_pc !== RESET_PC + 16'd9) begin
      errors++; $display("FAIL drain_last: got %h expected %h", last_pc, RESET_PC + 16'd9);
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    repeat (LAT + 1) tick();
    instr_ready = 1'b1;
    redirect = 1'b1;
    redirect_addr = 16'h0014;
    restart_sb(16'h0014);
    tick();
    redirect = 1'b0;
    @(negedge CLK);
    checks++;
    if (rom_address !== 16'h0014) begin errors++; $display("FAIL redir_addr: got %h expected 0014", rom_address); end
    for (int c = 0; c < LAT; c++) begin
      if (c != 0) @(negedge CLK);
      checks++;
      if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_gap c%0d: got %b expected 0", c, instr_valid); end
      tick();
    end
    @(negedge CLK);
    checks += 2;
    if (instr_pc !== 16'h0014) begin errors++; $display("FAIL redir_pc: got %h expected 0014", instr_pc); end
    if (instr !== rom_word(16'h0014)) begin
      errors++; $display("FAIL redir_instr: got %h expected %h", instr, rom_word(16'h0014));
    end
    tick();
  endtask

  task automatic test_back_to_back();
    redirect = 1'b1;
    redirect_addr = 16'h0040;
    restart_sb(16'h0040);
    tick();
    redirect_addr = 16'h0080;
    restart_sb(16'h0080);
    tick();
    redirect = 1'b0;
    wait_xfers(3);
    checks++;
    if (last_pc !== 16'h0082) begin errors++; $display("FAIL b2b_last: got %h expected 0082", last_pc); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1;
    redirect_addr = 16'hFFFF;
    restart_sb(16'hFFFF);
    tick();
    redirect = 1'b0;
    wait_xfers(3);
    checks++;
    if (last_pc !== 16'h0001) begin errors++; $display("FAIL wrap_last: got %h expected 0001", last_pc); end
  endtask

  task automatic test_reset_full();
    instr_ready = 1'b0;
    repeat (8) tick();
    RST = 1'b1;
    redirect = 1'b1;
    redirect_addr = 16'h0077;
    tick();
    RST = 1'b0;
    redirect = 1'b0;
    restart_sb(RESET_PC);
    @(negedge CLK);
    checks += 2;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL rstfull_valid: got %b expected 0", instr_valid); end
    if (rom_address !== RESET_PC) begin
      errors++; $display("FAIL rstfull_addr: got %h expected %h", rom_address, RESET_PC);
    end
    tick();
    instr_ready = 1'b1;
    wait_xfers(3);
    checks++;
    if (last_pc !== RESET_PC + 16'd2) begin
      errors++; $display("FAIL rstfull_last: got %h expected %h", last_pc, RESET_PC + 16'd2);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill_drain();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_reset_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
